// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multi-cycle RV32I core: IF/ID/EX/MEM/WB sequencing and datapath enables.
// Define ECALL_HALT_EN to let ECALL with halt_req=1 park the core in an absorbing HALT state.
module multicycle_control_fsm #(
  parameter int unsigned MEM_STALL_CYCLES = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic       alu_bcond,
  input  logic       halt_req,
  output logic       pc_write,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_ctrl_op,
  output logic       pc_source,
  output logic       is_halted,
  output logic [3:0] state_o
);

  localparam int unsigned CntW = (MEM_STALL_CYCLES > 0) ? $clog2(MEM_STALL_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_STALL_CYCLES);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  typedef enum logic [3:0] {
    StIf   = 4'd0,
    StId   = 4'd1,
    StEx   = 4'd2,
    StMem  = 4'd3,
    StWb   = 4'd4,
    StBr   = 4'd5,
    StPc4  = 4'd6,
    StJmp  = 4'd7,
    StHalt = 4'd8
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            last_cycle;

`ifndef ECALL_HALT_EN
  logic unused_halt_req;
  assign unused_halt_req = halt_req;
`endif

  assign last_cycle = (cnt_q == CntLast);
  assign state_o    = state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIf;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    i_or_d      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_to_reg  = 2'b00;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_ctrl_op = 2'b00;
    pc_source   = 1'b0;
    is_halted   = 1'b0;

    // Outputs are forced low for the whole reset assertion, not just after the edge.
    if (reset_n) begin
      unique case (state_q)
        StIf: begin
          mem_read = 1'b1;
          if (last_cycle) begin
            ir_write = 1'b1;
            state_d  = StId;
          end
        end
        StId: begin
          alu_src_b = 2'b10;
          case (opcode)
            OpR, OpI, OpLoad, OpStore, OpJalr: state_d = StEx;
            OpBranch:                          state_d = StBr;
            OpJal:                             state_d = StJmp;
`ifdef ECALL_HALT_EN
            OpSystem:                          state_d = halt_req ? StHalt : StPc4;
`else
            OpSystem:                          state_d = StPc4;
`endif
            default:                           state_d = StPc4;
          endcase
        end
        StEx: begin
          alu_src_a = 1'b1;
          case (opcode)
            OpR: begin
              alu_ctrl_op = 2'b10;
              state_d     = StWb;
            end
            OpI: begin
              alu_src_b   = 2'b10;
              alu_ctrl_op = 2'b01;
              state_d     = StWb;
            end
            OpLoad, OpStore: begin
              alu_src_b = 2'b10;
              state_d   = StMem;
            end
            OpJalr: begin
              alu_src_b = 2'b10;
              state_d   = StJmp;
            end
            default: state_d = StPc4;
          endcase
        end
        StMem: begin
          i_or_d    = 1'b1;
          mem_read  = (opcode == OpLoad);
          mem_write = (opcode == OpStore);
          if (last_cycle) begin
            if (opcode == OpLoad) begin
              state_d = StWb;
            end else if (opcode == OpStore) begin
              pc_write  = 1'b1;
              alu_src_b = 2'b01;
              state_d   = StIf;
            end else begin
              state_d = StPc4;
            end
          end
        end
        StWb: begin
          reg_write  = 1'b1;
          mem_to_reg = (opcode == OpLoad) ? 2'b01 : 2'b00;
          pc_write   = 1'b1;
          alu_src_b  = 2'b01;
          state_d    = StIf;
        end
        StBr: begin
          alu_src_a   = 1'b1;
          alu_ctrl_op = 2'b11;
          if (alu_bcond) begin
            pc_write  = 1'b1;
            pc_source = 1'b1;
            state_d   = StIf;
          end else begin
            state_d = StPc4;
          end
        end
        StPc4: begin
          pc_write  = 1'b1;
          alu_src_b = 2'b01;
          state_d   = StIf;
        end
        StJmp: begin
          alu_src_b  = 2'b01;
          reg_write  = 1'b1;
          mem_to_reg = 2'b10;
          pc_write   = 1'b1;
          pc_source  = 1'b1;
          state_d    = StIf;
        end
        StHalt: begin
`ifdef ECALL_HALT_EN
          is_halted = 1'b1;
`else
          state_d = StIf;
`endif
        end
        default: state_d = StIf;
      endcase
    end
  end

  // Counter only advances while waiting inside IF/MEM; any state change restarts it.
  always_comb begin
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == StIf || state_q == StMem) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: stall depths 0 and 3, table-driven latencies, random
// instruction streams against a per-instruction expected-cycle list, reset and halt corners.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_write;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_ctrl_op;
    logic       pc_source;
    logic       is_halted;
  } out_t;

  typedef struct {
    logic [6:0] op;
    logic       bc;
    int         lat;
  } vec_t;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpEcall  = 7'b1110011;
  localparam logic [6:0] OpLui    = 7'b0110111;

`ifdef ECALL_HALT_EN
  localparam bit HaltEn = 1'b1;
`else
  localparam bit HaltEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n [2];
  logic [6:0] opcode;
  logic       alu_bcond;
  logic       halt_req;

  logic       pc_write_w [2];
  logic       ir_write_w [2];
  logic       i_or_d_w [2];
  logic       mem_read_w [2];
  logic       mem_write_w [2];
  logic [1:0] mem_to_reg_w [2];
  logic       reg_write_w [2];
  logic       alu_src_a_w [2];
  logic [1:0] alu_src_b_w [2];
  logic [1:0] alu_ctrl_op_w [2];
  logic       pc_source_w [2];
  logic       is_halted_w [2];
  logic [3:0] state_w [2];
  out_t       obs [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Instance 0 has no memory stall, instance 1 stalls three extra cycles per access.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    multicycle_control_fsm #(
      .MEM_STALL_CYCLES(g == 0 ? 0 : 3)
    ) u_dut (
      .clk        (clk),
      .reset_n    (rst_n[g]),
      .opcode     (opcode),
      .alu_bcond  (alu_bcond),
      .halt_req   (halt_req),
      .pc_write   (pc_write_w[g]),
      .ir_write   (ir_write_w[g]),
      .i_or_d     (i_or_d_w[g]),
      .mem_read   (mem_read_w[g]),
      .mem_write  (mem_write_w[g]),
      .mem_to_reg (mem_to_reg_w[g]),
      .reg_write  (reg_write_w[g]),
      .alu_src_a  (alu_src_a_w[g]),
      .alu_src_b  (alu_src_b_w[g]),
      .alu_ctrl_op(alu_ctrl_op_w[g]),
      .pc_source  (pc_source_w[g]),
      .is_halted  (is_halted_w[g]),
      .state_o    (state_w[g])
    );
    assign obs[g] = {state_w[g], pc_write_w[g], ir_write_w[g], i_or_d_w[g], mem_read_w[g],
                     mem_write_w[g], mem_to_reg_w[g], reg_write_w[g], alu_src_a_w[g],
                     alu_src_b_w[g], alu_ctrl_op_w[g], pc_source_w[g], is_halted_w[g]};
  end

  out_t exp_q[$];

  function automatic out_t blank(input logic [3:0] st);
    out_t o;
    o = '0;
    o.st = st;
    return o;
  endfunction

  function automatic out_t pc_plus4(input out_t o_in);
    out_t o;
    o = o_in;
    o.pc_write = 1'b1;
    o.alu_src_b = 2'b01;
    return o;
  endfunction

  function automatic out_t jump_step();
    out_t o;
    o = blank(4'd7);
    o.alu_src_b = 2'b01;
    o.reg_write = 1'b1;
    o.mem_to_reg = 2'b10;
    o.pc_write = 1'b1;
    o.pc_source = 1'b1;
    return o;
  endfunction

  // Expected per-cycle outputs for one instruction, from fetch until it hands back to IF.
  function automatic void build(input logic [6:0] op, input logic bc, input logic hr,
                                input int n);
    out_t o;
    bit is_r, is_i, is_ld, is_st, is_jalr;
    is_r = (op == OpR);
    is_i = (op == OpI);
    is_ld = (op == OpLoad);
    is_st = (op == OpStore);
    is_jalr = (op == OpJalr);
    exp_q.delete();
    for (int i = 0; i <= n; i++) begin
      o = blank(4'd0);
      o.mem_read = 1'b1;
      o.ir_write = (i == n);
      exp_q.push_back(o);
    end
    o = blank(4'd1);
    o.alu_src_b = 2'b10;
    exp_q.push_back(o);
    if (is_r || is_i || is_ld || is_st || is_jalr) begin
      o = blank(4'd2);
      o.alu_src_a = 1'b1;
      o.alu_src_b = is_r ? 2'b00 : 2'b10;
      o.alu_ctrl_op = is_r ? 2'b10 : (is_i ? 2'b01 : 2'b00);
      exp_q.push_back(o);
      if (is_jalr) begin
        exp_q.push_back(jump_step());
      end else if (is_ld || is_st) begin
        for (int i = 0; i <= n; i++) begin
          o = blank(4'd3);
          o.i_or_d = 1'b1;
          o.mem_read = is_ld;
          o.mem_write = is_st;
          if (is_st && i == n) o = pc_plus4(o);
          exp_q.push_back(o);
        end
      end
      if (is_r || is_i || is_ld) begin
        o = blank(4'd4);
        o.reg_write = 1'b1;
        o.mem_to_reg = is_ld ? 2'b01 : 2'b00;
        exp_q.push_back(pc_plus4(o));
      end
    end else if (op == OpBranch) begin
      o = blank(4'd5);
      o.alu_src_a = 1'b1;
      o.alu_ctrl_op = 2'b11;
      o.pc_write = bc;
      o.pc_source = bc;
      exp_q.push_back(o);
      if (!bc) exp_q.push_back(pc_plus4(blank(4'd6)));
    end else if (op == OpJal) begin
      exp_q.push_back(jump_step());
    end else if (HaltEn && op == OpEcall && hr) begin
      o = blank(4'd8);
      o.is_halted = 1'b1;
      exp_q.push_back(o);
    end else begin
      exp_q.push_back(pc_plus4(blank(4'd6)));
    end
  endfunction

  function automatic void chk(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Entry/exit point: 1 time unit after the rising edge that starts this instruction's IF.
  task automatic run_instr(input int g, input logic [6:0] op, input logic bc, input logic hr,
                           output int lat);
    int nif;
    logic [3:0] st_k;
    nif = (g == 0) ? 1 : 4;
    build(op, bc, hr, nif - 1);
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      st_k = (k < exp_q.size()) ? exp_q[k].st : 4'd0;
      opcode = (st_k == 4'd0) ? 7'($urandom) : op;
      alu_bcond = (st_k == 4'd5) ? bc : 1'($urandom);
      halt_req = (st_k == 4'd1) ? hr : 1'($urandom);
      @(negedge clk);
      if (k >= exp_q.size()) begin
        chk_int($sformatf("overrun op=%b", op), k, exp_q.size() - 1);
        break;
      end
      chk($sformatf("g%0d op=%b cyc%0d", g, op, k), obs[g], exp_q[k]);
      @(posedge clk);
      #1;
      if (k + 1 >= nif && obs[g].st == 4'd0) begin
        lat = k + 1;
        break;
      end
    end
    chk_int($sformatf("latency g%0d op=%b", g, op), lat, exp_q.size());
  endtask

  task automatic do_reset(input int g);
    rst_n[g] = 1'b0;
    opcode = 7'($urandom);
    alu_bcond = 1'b1;
    halt_req = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk($sformatf("reset g%0d", g), obs[g], '0);
    end
    @(posedge clk);
    #1;
    rst_n[g] = 1'b1;
  endtask

  function automatic logic [6:0] rand_op();
    logic [6:0] ops [8];
    int idx;
    ops = '{OpR, OpI, OpLoad, OpStore, OpBranch, OpJal, OpJalr, OpLui};
    idx = int'($urandom_range(0, 8));
    return (idx == 8) ? 7'($urandom) : ops[idx];
  endfunction

  vec_t tbl [10];
  int   lat;
  logic [6:0] rop;
  out_t halt_exp;

  initial begin
    tbl[0] = '{OpR, 1'b0, 4};
    tbl[1] = '{OpI, 1'b0, 4};
    tbl[2] = '{OpLoad, 1'b0, 5};
    tbl[3] = '{OpStore, 1'b0, 4};
    tbl[4] = '{OpBranch, 1'b1, 3};
    tbl[5] = '{OpBranch, 1'b0, 4};
    tbl[6] = '{OpJal, 1'b0, 3};
    tbl[7] = '{OpJalr, 1'b0, 4};
    tbl[8] = '{OpLui, 1'b0, 3};
    tbl[9] = '{OpEcall, 1'b0, 3};

    rst_n[0] = 1'b0;
    rst_n[1] = 1'b0;
    opcode = '0;
    alu_bcond = 1'b0;
    halt_req = 1'b0;
    #2;
    do_reset(0);

    foreach (tbl[i]) begin
      run_instr(0, tbl[i].op, tbl[i].bc, 1'b0, lat);
      chk_int($sformatf("table%0d latency", i), lat, tbl[i].lat);
    end
    for (int i = 0; i < 40; i++) begin
      rop = rand_op();
      run_instr(0, rop, 1'($urandom), (rop == OpEcall) ? 1'b0 : 1'($urandom), lat);
    end

    rst_n[0] = 1'b0;
    do_reset(1);
    run_instr(1, OpLoad, 1'b0, 1'b0, lat);
    chk_int("load stall3 latency", lat, 11);

    // Store under stall 3, reset lands on the second MEM cycle.
    opcode = OpStore;
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    chk_int("store mem state", int'(obs[1].st), 3);
    chk_int("store mem_write", int'(obs[1].mem_write), 1);
    rst_n[1] = 1'b0;
    #1;
    chk("store reset immediate", obs[1], '0);
    @(posedge clk);
    #1;
    rst_n[1] = 1'b1;
    run_instr(1, OpR, 1'b0, 1'b0, lat);
    for (int i = 0; i < 15; i++) begin
      rop = rand_op();
      run_instr(1, rop, 1'($urandom), (rop == OpEcall) ? 1'b0 : 1'($urandom), lat);
    end

    rst_n[1] = 1'b0;
    do_reset(0);
    if (HaltEn) begin
      build(OpEcall, 1'b0, 1'b1, 0);
      halt_exp = exp_q[2];
      for (int k = 0; k < 2; k++) begin
        opcode = (k == 0) ? 7'($urandom) : OpEcall;
        halt_req = 1'b1;
        @(negedge clk);
        chk($sformatf("ecall cyc%0d", k), obs[0], exp_q[k]);
        @(posedge clk);
        #1;
      end
      for (int k = 0; k < 100; k++) begin
        opcode = 7'($urandom);
        alu_bcond = 1'($urandom);
        halt_req = 1'($urandom);
        @(negedge clk);
        if (k % 10 == 0 || obs[0] !== halt_exp) chk($sformatf("halt cyc%0d", k), obs[0], halt_exp);
        @(posedge clk);
        #1;
      end
      do_reset(0);
      run_instr(0, OpR, 1'b0, 1'b0, lat);
    end else begin
      run_instr(0, OpEcall, 1'b0, 1'b1, lat);
      chk_int("ecall no-halt latency", lat, 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
